// File: rtl/jtag_dtm.sv
// rtl/jtag_dtm.sv - JTAG debug transport module with oversampled TAP and DMI request/response port
//
// Purpose:
//   Samples asynchronous JTAG pins in the clk domain, runs a 16-state TAP
//   controller on detected TCK edges, and exposes IDCODE, DTMCS and DMI
//   registers behind a 5-bit IR. DMI scans become single requests on a
//   valid/ready handshake; the response is returned on a one-cycle strobe.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   tck_ns, tms_ns, tdi_ns   asynchronous JTAG inputs
//   tdo, tdo_oe              JTAG data out and its enable (Shift-DR/IR only)
//   dmi_req_*                request: valid/ready, addr, data, op (1 read, 2 write)
//   dmi_rsp_*                response: valid strobe, read data, error flag
module jtag_dtm #(
  parameter int unsigned ABITS        = 7,
  parameter logic [31:0] IDCODE_VALUE = 32'h00537291,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [2:0]  IDLE_HINT    = 3'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck_ns,
  input  logic             tms_ns,
  input  logic             tdi_ns,
  output logic             tdo,
  output logic             tdo_oe,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  input  logic [31:0]      dmi_rsp_data,
  input  logic             dmi_rsp_err
);

  localparam int DRW = int'(ABITS) + 34;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    REQ_IDLE, REQ_SEND, REQ_WAIT
  } req_state_t;

  // Pin synchronisers; TCK additionally keeps one history flop for edge detect.
  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic [SYNC_STAGES-1:0] r_tdi_sync;
  logic                   r_tck_hist;

  logic w_tck_re;
  logic w_tck_fe;
  logic w_tms;
  logic w_tdi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_tck_hist <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck_ns};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms_ns};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi_ns};
      r_tck_hist <= r_tck_sync[SYNC_STAGES-1];
    end
  end

  assign w_tck_re = r_tck_sync[SYNC_STAGES-1] & ~r_tck_hist;
  assign w_tck_fe = ~r_tck_sync[SYNC_STAGES-1] & r_tck_hist;
  assign w_tms    = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi    = r_tdi_sync[SYNC_STAGES-1];

  // TAP controller
  tap_state_t r_tap_state;
  tap_state_t w_tap_next;

  always_ff @(posedge clk) begin
    if (rst) r_tap_state <= TLR;
    else     r_tap_state <= w_tap_next;
  end

  always_comb begin
    w_tap_next = r_tap_state;
    if (w_tck_re) begin
      unique case (r_tap_state)
        TLR:    w_tap_next = w_tms ? TLR    : RTI;
        RTI:    w_tap_next = w_tms ? SEL_DR : RTI;
        SEL_DR: w_tap_next = w_tms ? SEL_IR : CAP_DR;
        CAP_DR: w_tap_next = w_tms ? EX1_DR : SH_DR;
        SH_DR:  w_tap_next = w_tms ? EX1_DR : SH_DR;
        EX1_DR: w_tap_next = w_tms ? UPD_DR : PAU_DR;
        PAU_DR: w_tap_next = w_tms ? EX2_DR : PAU_DR;
        EX2_DR: w_tap_next = w_tms ? UPD_DR : SH_DR;
        UPD_DR: w_tap_next = w_tms ? SEL_DR : RTI;
        SEL_IR: w_tap_next = w_tms ? TLR    : CAP_IR;
        CAP_IR: w_tap_next = w_tms ? EX1_IR : SH_IR;
        SH_IR:  w_tap_next = w_tms ? EX1_IR : SH_IR;
        EX1_IR: w_tap_next = w_tms ? UPD_IR : PAU_IR;
        PAU_IR: w_tap_next = w_tms ? EX2_IR : PAU_IR;
        EX2_IR: w_tap_next = w_tms ? UPD_IR : SH_IR;
        UPD_IR: w_tap_next = w_tms ? SEL_DR : RTI;
      endcase
    end
  end

  // DTM state
  logic [4:0]       r_ir;
  logic [4:0]       r_ir_sr;
  logic [DRW-1:0]   r_dr;
  logic             r_tdo;
  logic             r_tdo_oe;
  logic [1:0]       r_dmistat;
  logic [ABITS-1:0] r_dmi_addr;
  logic [31:0]      r_dmi_data;
  logic [1:0]       r_req_op;
  req_state_t       r_req_state;
  req_state_t       w_req_next;

  logic             w_sel_idcode;
  logic             w_sel_dtmcs;
  logic             w_sel_dmi;
  logic             w_busy;
  logic [1:0]       w_cap_op;
  logic [31:0]      w_dtmcs_rd;
  logic [DRW-1:0]   w_dr_cap;
  logic [DRW-1:0]   w_dr_shift;
  logic             w_cap_dmi;
  logic             w_upd_dr;
  logic             w_dtmcs_wr;
  logic             w_dmireset;
  logic             w_hardreset;
  logic             w_dmi_upd;
  logic [1:0]       w_upd_op;
  logic [31:0]      w_upd_data;
  logic [ABITS-1:0] w_upd_addr;
  logic             w_dmi_start;
  logic             w_rsp_take;

  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_dtmcs  = (r_ir == IR_DTMCS);
  assign w_sel_dmi    = (r_ir == IR_DMI);

  // busy is exactly "a request is in flight", so it is derived from the FSM.
  assign w_busy   = (r_req_state != REQ_IDLE);
  assign w_cap_op = w_busy ? 2'd3 : r_dmistat;

  assign w_dtmcs_rd = {17'b0, IDLE_HINT, r_dmistat, 6'(ABITS), 4'd1};

  always_comb begin
    w_dr_cap = '0;
    if (w_sel_dmi)         w_dr_cap = {r_dmi_addr, r_dmi_data, w_cap_op};
    else if (w_sel_idcode) w_dr_cap[31:0] = IDCODE_VALUE | 32'h1;
    else if (w_sel_dtmcs)  w_dr_cap[31:0] = w_dtmcs_rd;
  end

  // TDI enters at the MSB of the currently selected register length.
  always_comb begin
    w_dr_shift = '0;
    if (w_sel_dmi)                        w_dr_shift = {w_tdi, r_dr[DRW-1:1]};
    else if (w_sel_idcode || w_sel_dtmcs) w_dr_shift[31:0] = {w_tdi, r_dr[31:1]};
    else                                  w_dr_shift[0] = w_tdi;
  end

  assign w_cap_dmi   = w_tck_re && (r_tap_state == CAP_DR) && w_sel_dmi;
  assign w_upd_dr    = w_tck_re && (r_tap_state == UPD_DR);
  assign w_dtmcs_wr  = w_upd_dr && w_sel_dtmcs;
  assign w_dmireset  = w_dtmcs_wr && r_dr[16];
  assign w_hardreset = w_dtmcs_wr && r_dr[17];
  assign w_dmi_upd   = w_upd_dr && w_sel_dmi;
  assign w_upd_op    = r_dr[1:0];
  assign w_upd_data  = r_dr[33:2];
  assign w_upd_addr  = r_dr[DRW-1:34];
  assign w_dmi_start = w_dmi_upd && (r_dmistat == 2'd0) && !w_busy &&
                       ((w_upd_op == 2'd1) || (w_upd_op == 2'd2));
  // A hardreset in the same cycle as a response drops the response.
  assign w_rsp_take  = (r_req_state == REQ_WAIT) && dmi_rsp_valid && !w_hardreset;

  // IR / DR / TDO datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir     <= IR_IDCODE;
      r_ir_sr  <= '0;
      r_dr     <= '0;
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      if (w_tck_re) begin
        case (r_tap_state)
          TLR:     r_ir    <= IR_IDCODE;
          CAP_IR:  r_ir_sr <= 5'b00001;
          SH_IR:   r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
          UPD_IR:  r_ir    <= r_ir_sr;
          CAP_DR:  r_dr    <= w_dr_cap;
          SH_DR:   r_dr    <= w_dr_shift;
          default: ;
        endcase
      end
      // The falling edge presents the bit that the next rising edge shifts out.
      if (w_tck_fe) begin
        r_tdo_oe <= (r_tap_state == SH_DR) || (r_tap_state == SH_IR);
        if (r_tap_state == SH_DR)      r_tdo <= r_dr[0];
        else if (r_tap_state == SH_IR) r_tdo <= r_ir_sr[0];
        else                           r_tdo <= 1'b0;
      end
    end
  end

  // Sticky status. Later statements take priority: a clear beats a busy
  // violation, and a response error beats everything it can coincide with.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmistat <= 2'd0;
    end else begin
      if (w_cap_dmi && w_busy && (r_dmistat == 2'd0)) r_dmistat <= 2'd3;
      if (w_dmi_upd && w_busy && (r_dmistat == 2'd0)) r_dmistat <= 2'd3;
      if (w_dmireset || w_hardreset)                  r_dmistat <= 2'd0;
      if (w_rsp_take && dmi_rsp_err)                  r_dmistat <= 2'd2;
    end
  end

  // Request address/data/op. The data register doubles as the response
  // holding register: reads overwrite it, writes keep the written value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmi_addr <= '0;
      r_dmi_data <= '0;
      r_req_op   <= 2'd0;
    end else if (w_dmi_start) begin
      r_dmi_addr <= w_upd_addr;
      r_dmi_data <= w_upd_data;
      r_req_op   <= w_upd_op;
    end else if (w_rsp_take && (r_req_op == 2'd1)) begin
      r_dmi_data <= dmi_rsp_data;
    end
  end

  // Request FSM
  always_ff @(posedge clk) begin
    if (rst) r_req_state <= REQ_IDLE;
    else     r_req_state <= w_req_next;
  end

  always_comb begin
    w_req_next = r_req_state;
    unique case (r_req_state)
      REQ_IDLE: if (w_dmi_start)   w_req_next = REQ_SEND;
      REQ_SEND: if (dmi_req_ready) w_req_next = REQ_WAIT;
      REQ_WAIT: if (dmi_rsp_valid) w_req_next = REQ_IDLE;
      default:                     w_req_next = REQ_IDLE;
    endcase
    if (w_hardreset) w_req_next = REQ_IDLE;
  end

  assign dmi_req_valid = (r_req_state == REQ_SEND);
  assign dmi_req_addr  = r_dmi_addr;
  assign dmi_req_data  = r_dmi_data;
  assign dmi_req_op    = r_req_op;
  assign tdo           = r_tdo;
  assign tdo_oe        = r_tdo_oe;

endmodule

// File: doc/jtag_dtm.md
# jtag_dtm

Parametrised JTAG Debug Transport Module, the next generation of the team's DTM. Oversampled JTAG pins drive a full 16-state TAP controller in the system clock domain. The block exposes IDCODE, DTMCS and DMI access registers and issues DMI reads and writes over a valid/ready request and response handshake. Adds over the previous DTM: configurable address width, busy and error reporting through `dmistat` and `op`, `dmireset`/`dmihardreset`, and a `tdo_oe` output.

## Interface
- `ABITS`, 7, DMI address width (1..32); the DMI register is ABITS+34 bits.
- `IDCODE_VALUE`, 32'h00537291, IDCODE register content; bit 0 is forced to 1.
- `SYNC_STAGES`, 2, synchroniser flops per JTAG input (≥2).
- `IDLE_HINT`, 3'd1, value reported in `dtmcs.idle`.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `tck_ns`, `tms_ns`, `tdi_ns` in 1 each: asynchronous JTAG pins.
- `tdo` out 1: JTAG data out.
- `tdo_oe` out 1: high while in Shift-DR/Shift-IR.
- `dmi_req_valid` out 1, `dmi_req_ready` in 1: request handshake.
- `dmi_req_addr` out ABITS, `dmi_req_data` out 32, `dmi_req_op` out 2 (1=read, 2=write).
- `dmi_rsp_valid` in 1: single-cycle response strobe.
- `dmi_rsp_data` in 32, `dmi_rsp_err` in 1.

## Operation
- Each pin passes through SYNC_STAGES flops plus one history flop. `tck_re`/`tck_fe` are single-`clk` strobes.
- TAP: standard IEEE 1149.1 states, advanced on `tck_re` using the synchronised TMS. Five TCK cycles with TMS=1 reach Test-Logic-Reset from any state.
- IR is 5 bits. Reset value is IDCODE (0x01), also loaded in Test-Logic-Reset. Capture-IR loads 5'b00001. The IR updates in Update-IR.
- Decode: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (ABITS+34b). Anything else, including 0x00 and 0x1F, selects 1-bit BYPASS (captures 0).
- Shift: LSB first. On each `tck_re` in Shift-xR, the register shifts right with TDI into the MSB of the selected length. The captured LSB appears on `tdo` at the first `tck_fe` in Shift.
- DTMCS read layout: [3:0]=1, [9:4]=ABITS, [11:10]=dmistat, [14:12]=IDLE_HINT, rest 0.
- DTMCS write on Update-DR:
  - bit16 (`dmireset`) clears sticky `dmistat`.
  - bit17 (`dmihardreset`) clears `dmistat` and `busy` and drops `dmi_req_valid`.
  - Any response still outstanding is then discarded.
- DMI capture, layout {addr, data, op}:
  - addr and data are the last request address and the last response data.
  - op = 3 if `busy`, otherwise `dmistat`.
  - Capturing while `busy` sets `dmistat`=3.
- DMI Update-DR:
  - If `dmistat`≠0, ignore.
  - Else if `busy`, set `dmistat`=3 and ignore.
  - Else, op 1 or 2 latches addr/data/op, sets `busy` and asserts `dmi_req_valid`. Op 0 or 3 does nothing.
- Request FSM, states IDLE → REQ → WAIT → IDLE:
  - REQ holds valid, addr, data and op stable until `dmi_req_ready`.
  - WAIT ends on `dmi_rsp_valid`: latch `dmi_rsp_data` (reads only; writes keep the written data) and clear `busy`.
  - `dmi_rsp_err`=1 sets `dmistat`=2.
  - `dmi_rsp_valid` is ignored in IDLE and REQ.
- `dmistat` is sticky. Once it is 2, it stays 2 until cleared (busy does not overwrite an error).

## Timing
- Reset values: `tdo`=0, `tdo_oe`=0, `dmi_req_valid`=0, `dmi_req_addr`/`dmi_req_data`/`dmi_req_op`=0. Also TAP=Test-Logic-Reset, IR=0x01, `dmistat`=0, `busy`=0, sync flops=0.
- A pin edge produces its strobe SYNC_STAGES+1 `clk` after it settles. TCK high and low phases must each be ≥ SYNC_STAGES+2 `clk`.
- `tdo` and `tdo_oe` change only on `tck_fe`. `tdo_oe` reflects the state after the preceding `tck_re`.
- `dmi_req_valid` rises 1 `clk` after the `tck_re` that leaves Update-DR. It falls the cycle after `valid && ready`.
- Ready may be high in the same cycle valid rises: 1-cycle handshake, WAIT entered next cycle.
- Response in the same `clk` as a `tck_re` capturing DMI: the capture sees `busy`=1, so op=3 and `dmistat`=3.
- Simultaneous `dmihardreset` and response: hardreset wins and the response is dropped.
- `rst` mid-transaction: everything returns to reset values immediately. A later `dmi_rsp_valid` is ignored.
- TCK stalled mid-shift: all state holds indefinitely.

## Test plan
- Reset, then 5×TMS=1, go to Shift-DR, shift 32 bits → TDO stream equals 0x00537291 LSB first, and `tdo_oe`=1 only during the 32 shifts.
- IR=0x10, capture DTMCS with ABITS=7 → 0x00001071. Then write bit16 while `dmistat`=2 → a recapture reads 0x00001071.
- IR=0x11, shift {addr=0x10, data=0, op=1} → one request on the DMI handshake (addr 0x10, op 1). Respond with data 0xDEADBEEF → the next capture yields op=0, data=0xDEADBEEF, addr 0x10.
- Hold `dmi_req_ready`=0 and capture DMI → op=3. Then a write scan is ignored. After the response, capture → op=3 (sticky) until `dmireset`.
- Response with `dmi_rsp_err`=1 → capture op=2, and later reads are not issued. Then `dmihardreset` with ready still low on a fresh request → valid drops and a late response is ignored.
- Assert `rst` during WAIT → all outputs return to reset values. A response pulse 3 `clk` later produces no state change, and IR reads back 5'b00001 on capture.
